// File: rtl/signal_safety_monitor.sv
// Safety monitor between the traffic light controller and the lamp drivers.
// Legal patterns pass through one register stage. A filtered violation latches
// flashing-amber mode until a clear handshake and an all-red clearance.
// Optional lamp feedback check: define LAMP_FEEDBACK_EN to add the lamp_fb input.
module signal_safety_monitor #(
    parameter int unsigned FILTER_CYC   = 2,
    parameter int unsigned MAX_GREEN    = 15,
    parameter int unsigned ALLRED_TICKS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [2:0]  light_M1_in,
    input  logic [2:0]  light_M2_in,
    input  logic [2:0]  light_MT_in,
    input  logic [2:0]  light_S_in,
`ifdef LAMP_FEEDBACK_EN
    input  logic [11:0] lamp_fb,
`endif
    input  logic        clear_req,
    output logic [2:0]  lamp_M1,
    output logic [2:0]  lamp_M2,
    output logic [2:0]  lamp_MT,
    output logic [2:0]  lamp_S,
    output logic        fault,
    output logic [3:0]  fault_code,
    output logic        clear_ack,
    output logic [7:0]  fault_cnt
);

    localparam logic [2:0] Green = 3'b001;
    localparam logic [2:0] Amber = 3'b010;
    localparam logic [2:0] Red   = 3'b100;
    localparam logic [2:0] Off   = 3'b000;

    typedef enum logic [1:0] {StAllRed, StPass, StFlash} state_e;

    state_e           state_q, state_d;
    logic [3:0][2:0]  light;
    logic [3:0][2:0]  lamp_q, lamp_d;
    logic [3:0][7:0]  green_q, green_d;
    logic [3:0]       filt_q, filt_d;
    logic [7:0]       tcnt_q, tcnt_d;
    logic             phase_q, phase_d;
    logic [3:0]       code_q, code_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             ack_q, ack_d;

    logic             v_enc, v_conf, v_tmo, viol, filt_det;
    logic             fb_fault, fb_ok, detect, accept;
    logic [3:0]       causes;

    // Index 3 is M1, index 0 is S, matching the {M1,M2,MT,S} ordering.
    assign light = {light_M1_in, light_M2_in, light_MT_in, light_S_in};

    // Raw violations on the current inputs and the registered green counters.
    always_comb begin
        v_enc = 1'b0;
        v_tmo = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (light[i] != Green && light[i] != Amber && light[i] != Red) v_enc = 1'b1;
            if (green_q[i] == 8'(MAX_GREEN)) v_tmo = 1'b1;
        end
    end

    assign v_conf = (light_S_in != Red &&
                     (light_M1_in != Red || light_M2_in != Red || light_MT_in != Red)) ||
                    (light_MT_in != Red && light_M2_in != Red);
    assign viol     = v_enc | v_conf | v_tmo;
    // Fault fires on the cycle the persistence count reaches FILTER_CYC.
    assign filt_det = viol && (filt_q >= 4'(FILTER_CYC - 1));

    // Per-approach green duration counters and the glitch filter counter.
    always_comb begin
        green_d = green_q;
        for (int i = 0; i < 4; i++) begin
            if (light[i] != Green) begin
                green_d[i] = 8'd0;
            end else if (tick && green_q[i] != 8'hFF) begin
                green_d[i] = green_q[i] + 8'd1;
            end
        end
        filt_d = 4'd0;
        if (viol) filt_d = (filt_q == 4'(FILTER_CYC)) ? filt_q : filt_q + 4'd1;
    end

`ifdef LAMP_FEEDBACK_EN
    logic [2:0] fb_cnt_q, fb_cnt_d;
    logic       fb_mismatch;

    assign fb_mismatch = (lamp_fb != lamp_q);
    assign fb_fault    = (state_q != StFlash) && fb_mismatch && (fb_cnt_q == 3'd3);
    assign fb_ok       = !fb_mismatch;

    // Count consecutive feedback mismatches; not evaluated while flashing.
    always_comb begin
        fb_cnt_d = 3'd0;
        if (state_q != StFlash && fb_mismatch && fb_cnt_q != 3'd4) fb_cnt_d = fb_cnt_q + 3'd1;
        else if (state_q != StFlash && fb_mismatch) fb_cnt_d = fb_cnt_q;
    end

    // Feedback mismatch counter register.
    always_ff @(posedge clk) begin
        if (!rst) fb_cnt_q <= 3'd0;
        else      fb_cnt_q <= fb_cnt_d;
    end
`else
    assign fb_fault = 1'b0;
    assign fb_ok    = 1'b1;
`endif

    assign detect = filt_det | fb_fault;
    assign causes = {fb_fault, filt_det ? {v_tmo, v_conf, v_enc} : 3'b000};
    // A fault in the same cycle always beats a clear request.
    assign accept = (state_q == StFlash) && clear_req && !viol && (filt_q == 4'd0) &&
                    fb_ok && !detect;

    // Mode sequencing, fault bookkeeping and next lamp drive.
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        phase_d = phase_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        lamp_d  = {4{Red}};
        if (detect) begin
            state_d = StFlash;
            code_d  = code_q | causes;
            if (state_q != StFlash) begin
                phase_d = 1'b0;
                if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
            end else if (tick) begin
                phase_d = ~phase_q;
            end
        end else if (accept) begin
            state_d = StAllRed;
            code_d  = 4'd0;
            tcnt_d  = 8'd0;
            ack_d   = 1'b1;
        end else begin
            case (state_q)
                StAllRed: begin
                    if (tick) begin
                        if (tcnt_q == 8'(ALLRED_TICKS - 1)) begin
                            state_d = StPass;
                            tcnt_d  = 8'd0;
                        end else begin
                            tcnt_d = tcnt_q + 8'd1;
                        end
                    end
                end
                StFlash: if (tick) phase_d = ~phase_q;
                default: ;
            endcase
        end
        // Lamps follow the next state so a fault entry already drives flash values.
        case (state_d)
            StPass:  lamp_d = light;
            StFlash: lamp_d = phase_d ? {4{Off}} : {4{Amber}};
            default: lamp_d = {4{Red}};
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StAllRed;
            lamp_q  <= {4{Red}};
            green_q <= '0;
            filt_q  <= 4'd0;
            tcnt_q  <= 8'd0;
            phase_q <= 1'b0;
            code_q  <= 4'd0;
            cnt_q   <= 8'd0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lamp_q  <= lamp_d;
            green_q <= green_d;
            filt_q  <= filt_d;
            tcnt_q  <= tcnt_d;
            phase_q <= phase_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
        end
    end

    assign lamp_M1    = lamp_q[3];
    assign lamp_M2    = lamp_q[2];
    assign lamp_MT    = lamp_q[1];
    assign lamp_S     = lamp_q[0];
    assign fault      = (state_q == StFlash);
    assign fault_code = code_q;
    assign clear_ack  = ack_q;
    assign fault_cnt  = cnt_q;

endmodule

// File: doc/signal_safety_monitor.md
Name: signal_safety_monitor

Overview:
- Sits directly downstream of the traffic light controller, between its four 3-bit light vectors and the physical lamp drivers.
- Passes legal light patterns through to the lamps with one registered stage.
- Detects unsafe or illegal patterns: invalid encoding, conflicting greens, green held too long.
- On any filtered fault, latches into a fail-safe flashing-amber mode. Leaves it only via an explicit clear handshake and an all-red clearance interval.

Parameters:
- FILTER_CYC, 2: clk cycles a raw violation must persist before it becomes a fault (glitch filter); range 1..15.
- MAX_GREEN, 15: max consecutive ticks any single approach may show green; a count reaching this value is a fault.
- ALLRED_TICKS, 3: ticks of all-red clearance after reset and after a fault clear.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low; sampled on posedge clk
- tick  in  1  one-cycle timebase enable pulse (1 Hz nominal)
- light_M1_in  in  3  controller output, main road 1
- light_M2_in  in  3  controller output, main road 2
- light_MT_in  in  3  controller output, main turn
- light_S_in  in  3  controller output, side road
- clear_req  in  1  one-cycle request to leave fault mode
- lamp_M1  out  3  lamp drive, main road 1
- lamp_M2  out  3  lamp drive, main road 2
- lamp_MT  out  3  lamp drive, main turn
- lamp_S  out  3  lamp drive, side road
- fault  out  1  high while in FLASH state
- fault_code  out  4  sticky cause bits
- clear_ack  out  1  one-cycle pulse when clear_req is accepted
- fault_cnt  out  8  saturating count of fault entries

Behaviour:
- Encoding for every 3-bit vector: 3'b001 green, 3'b010 amber, 3'b100 red. Any other value is invalid, including 3'b000.
- Raw violations, evaluated combinationally each cycle on the inputs:
  - V_ENC: any input not exactly one of the three legal codes.
  - V_CONF: light_S_in non-red while any of M1/M2/MT is non-red; or light_MT_in non-red while light_M2_in non-red.
  - V_TMO: any approach's green counter == MAX_GREEN.
- Green counters:
  - One 8-bit counter per approach.
  - Increments on tick while that input is green; cleared when the input is not green.
  - Saturates at 255; active in every state.
- Filter: a 4-bit counter increments each cycle any raw violation is present and clears to 0 when none is present. Fault is detected when the counter reaches FILTER_CYC.
- States:
  - ALL_RED:
    - All lamps 3'b100.
    - Tick counter increments on tick.
    - At ALLRED_TICKS goes to PASS; the tick counter clears.
    - A detected fault goes to FLASH and takes priority.
  - PASS:
    - Lamps register the inputs; one cycle latency from input to lamp.
    - A detected fault goes to FLASH next cycle. The lamp outputs in that transition cycle already show flash values.
  - FLASH:
    - lamp_M1/M2/MT/S all 3'b010 or all 3'b000.
    - Phase bit toggles on each tick, starting at 3'b010 on entry.
    - fault=1.
- Fault entry:
  - ORs the cause bits into fault_code: bit0 V_ENC, bit1 V_CONF, bit2 V_TMO, bit3 feedback.
  - Increments fault_cnt, saturating at 255.
  - Faults detected while already in FLASH OR into fault_code without incrementing fault_cnt.
- Clear handshake:
  - clear_req is accepted only in FLASH, with no raw violation present that cycle and filter counter 0.
  - On acceptance: clear_ack=1 for one cycle, fault_code clears to 0, state goes to ALL_RED, tick counter clears.
  - clear_req outside FLASH, or while a violation is present: ignored, no clear_ack.
  - Fault detection and clear_req in the same cycle: the fault wins, the state stays FLASH, no clear_ack.
- Reset (rst=0 at posedge, any state, mid-operation):
  - state ALL_RED, lamps 3'b100, fault=0, fault_code=0, clear_ack=0, fault_cnt=0.
  - All counters 0, flash phase 0.

Optional Feature:
- Macro: LAMP_FEEDBACK_EN.
- Defined:
  - Adds input lamp_fb[11:0], ordered {M1,M2,MT,S} as sensed lamp states.
  - A mismatch between lamp_fb and the registered lamp outputs, persisting 4 consecutive cycles in PASS or ALL_RED, is a fault with fault_code bit3.
  - Clear acceptance additionally requires lamp_fb to match.
  - The feedback check is not evaluated in FLASH.
- Undefined: no lamp_fb port; fault_code bit3 is constant 0.

Test Plan:
- Reset, rst=0 for 2 cycles then 1, inputs legal → lamps 3'b100 for 3 ticks, then lamps equal inputs one cycle later; fault=0, fault_cnt=0.
- In PASS, drive light_S_in=001 and light_M1_in=001 for 1 cycle only → no fault (filter). Hold it 2 cycles → fault=1, fault_code=4'b0010, fault_cnt=1, lamps alternate 010/000 on each tick.
- In PASS, light_MT_in=3'b000 for 2 cycles → FLASH, fault_code=4'b0001.
- Hold light_M1_in=001 with the rest red for 15 ticks → fault_code=4'b0100 and FLASH.
- In FLASH:
  - clear_req while the conflict is still present → no clear_ack, fault stays 1.
  - Remove the conflict, then clear_req → clear_ack pulse, fault_code=0, lamps 3'b100 for 3 ticks, then PASS.
- In FLASH, a new conflict detected in the same cycle as clear_req → no ack, fault_cnt unchanged. Then assert rst=0 mid-FLASH → ALL_RED, fault_cnt=0.
